// File: rtl/sodor5_verif.sv
// sodor5_verif: lockstep differential checker for a 5-stage RV32I integer pipeline.
// One instruction word per cycle drives both a 5-stage pipelined core (coretop) and a
// single-cycle ISA model (s5m). The model result is delayed PIPE_LAT cycles and compared
// with the pipeline's writeback every cycle.
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset (register/dmem contents are preserved)
//   instr           instruction word, consumed every cycle
//   retire_valid    pipeline WB stage writes a register this cycle
//   retire_rd       WB destination register
//   retire_data     WB write data
//   mismatch        this cycle's WB differs from the delayed model result
//   mismatch_sticky set on any mismatch, cleared only by reset

package sodor5_pkg;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpLoad = 7'b0000011;

    function automatic logic writes_rd(input logic [6:0] opcode, input logic [2:0] f3,
                                       input logic [4:0] rd);
        logic ok;
        ok = 1'b0;
        if (opcode == OpImm) begin
            ok = 1'b1;
        end else if (opcode == OpLoad) begin
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        return ok && (rd != 5'd0);
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

    function automatic logic [31:0] op_imm(input logic [2:0] f3, input logic [11:0] imm,
                                           input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  sh;
        b  = sext12(imm);
        sh = imm[4:0];
        r  = '0;
        case (f3)
            3'd0: r = a + b;
            3'd1: r = a << sh;
            3'd2: r = {31'd0, $signed(a) < $signed(b)};
            3'd3: r = {31'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin
                // imm[10] selects arithmetic shift
                if (imm[10]) r = $signed(a) >>> sh;
                else         r = a >> sh;
            end
            3'd6: r = a | b;
            3'd7: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] sh_w;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh_w = w >> {lo, 3'b000};
        b    = sh_w[7:0];
        h    = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = w;
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = '0;
        endcase
        return r;
    endfunction
endpackage

// Register file, x0 reads as zero, write-first bypass on the read port.
module sodor5_regfile #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regfile [NUM_REGS];

    always_ff @(posedge clk) begin
        if (wen) regfile[waddr] <= wdata;
    end

    always_comb begin
        rdata = regfile[raddr];
        if (raddr == 5'd0)                 rdata = '0;
        else if (wen && (waddr == raddr))  rdata = wdata;
    end
endmodule

// Data memory, combinational read. The write port is a backdoor, tied off in operation.
module sodor5_dmem #(
    parameter int unsigned DMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic [3:0]  idx,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [3:0]  widx,
    input  logic [31:0] wdata
);
    logic [31:0] mem [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (wen) mem[widx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

// Pipeline datapath: IF/ID -> ID/EX -> EX/MEM -> MEM/WB, regfile written at end of WB.
module sodor5_dpath #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    output logic [3:0]  dmem_idx,
    input  logic [31:0] dmem_rdata,
    output logic        retire_valid,
    output logic [4:0]  retire_rd,
    output logic [31:0] retire_data
);
    import sodor5_pkg::*;

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        ex_wen_q, ex_wen_d;
    logic [31:0] ex_instr_q, ex_instr_d;
    logic [31:0] ex_rs1_q, ex_rs1_d;
    logic        mem_wen_q, mem_wen_d;
    logic        mem_load_q, mem_load_d;
    logic [4:0]  mem_rd_q, mem_rd_d;
    logic [2:0]  mem_f3_q, mem_f3_d;
    logic [31:0] mem_alu_q, mem_alu_d;
    logic        wb_wen_q, wb_wen_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [31:0] id_rs1_val;
    logic [4:0]  ex_rs1;
    logic [31:0] ex_a, ex_result;
    logic [31:0] mem_result;

    sodor5_regfile #(.NUM_REGS(NUM_REGS)) regfile (
        .clk   (clk),
        .raddr (id_instr_q[19:15]),
        .rdata (id_rs1_val),
        .wen   (wb_wen_q),
        .waddr (wb_rd_q),
        .wdata (wb_data_q)
    );

    // MEM stage: combinational dmem read and load extraction
    always_comb begin
        dmem_idx   = mem_alu_q[5:2];
        mem_result = mem_alu_q;
        if (mem_load_q) mem_result = load_ext(mem_f3_q, mem_alu_q[1:0], dmem_rdata);
    end

    // EX stage operand forwarding, MEM beats WB beats the ID-stage read
    always_comb begin
        ex_rs1 = ex_instr_q[19:15];
        ex_a   = ex_rs1_q;
        if (mem_wen_q && (mem_rd_q == ex_rs1))     ex_a = mem_result;
        else if (wb_wen_q && (wb_rd_q == ex_rs1))  ex_a = wb_data_q;
        if (ex_instr_q[6:0] == OpLoad) ex_result = ex_a + sext12(ex_instr_q[31:20]);
        else ex_result = op_imm(ex_instr_q[14:12], ex_instr_q[31:20], ex_a);
    end

    always_comb begin
        id_valid_d = 1'b1;
        id_instr_d = instr;
        ex_wen_d   = id_valid_q
                     && writes_rd(id_instr_q[6:0], id_instr_q[14:12], id_instr_q[11:7]);
        ex_instr_d = id_instr_q;
        ex_rs1_d   = id_rs1_val;
        mem_wen_d  = ex_wen_q;
        mem_load_d = (ex_instr_q[6:0] == OpLoad);
        mem_rd_d   = ex_instr_q[11:7];
        mem_f3_d   = ex_instr_q[14:12];
        mem_alu_d  = ex_result;
        wb_wen_d   = mem_wen_q;
        wb_rd_d    = mem_rd_q;
        wb_data_d  = mem_result;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            ex_wen_q   <= 1'b0;
            ex_instr_q <= '0;
            ex_rs1_q   <= '0;
            mem_wen_q  <= 1'b0;
            mem_load_q <= 1'b0;
            mem_rd_q   <= '0;
            mem_f3_q   <= '0;
            mem_alu_q  <= '0;
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            ex_wen_q   <= ex_wen_d;
            ex_instr_q <= ex_instr_d;
            ex_rs1_q   <= ex_rs1_d;
            mem_wen_q  <= mem_wen_d;
            mem_load_q <= mem_load_d;
            mem_rd_q   <= mem_rd_d;
            mem_f3_q   <= mem_f3_d;
            mem_alu_q  <= mem_alu_d;
            wb_wen_q   <= wb_wen_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign retire_valid = wb_wen_q;
    assign retire_rd    = wb_rd_q;
    assign retire_data  = wb_data_q;
endmodule

module sodor5_core #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    output logic [3:0]  dmem_idx,
    input  logic [31:0] dmem_rdata,
    output logic        retire_valid,
    output logic [4:0]  retire_rd,
    output logic [31:0] retire_data
);
    sodor5_dpath #(.NUM_REGS(NUM_REGS)) d (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr        (instr),
        .dmem_idx     (dmem_idx),
        .dmem_rdata   (dmem_rdata),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data)
    );
endmodule

module sodor5_coretop #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    output logic        retire_valid,
    output logic [4:0]  retire_rd,
    output logic [31:0] retire_data
);
    logic [3:0]  dmem_idx;
    logic [31:0] dmem_rdata;

    sodor5_core #(.NUM_REGS(NUM_REGS)) core (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr        (instr),
        .dmem_idx     (dmem_idx),
        .dmem_rdata   (dmem_rdata),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data)
    );

    sodor5_dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem (
        .clk   (clk),
        .idx   (dmem_idx),
        .rdata (dmem_rdata),
        .wen   (1'b0),
        .widx  (4'd0),
        .wdata (32'd0)
    );
endmodule

// Single-cycle reference model; its regfile updates at the edge that captures instr.
module sodor5_model #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    output logic        res_valid,
    output logic [4:0]  res_rd,
    output logic [31:0] res_data
);
    import sodor5_pkg::*;

    logic [31:0] regfile [NUM_REGS];
    logic [31:0] rs1_val, addr, word;
    logic        unused_addr;

    assign rs1_val     = (instr[19:15] == 5'd0) ? 32'd0 : regfile[instr[19:15]];
    assign addr        = rs1_val + sext12(instr[31:20]);
    assign unused_addr = ^addr[31:6];

    sodor5_dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem (
        .clk   (clk),
        .idx   (addr[5:2]),
        .rdata (word),
        .wen   (1'b0),
        .widx  (4'd0),
        .wdata (32'd0)
    );

    always_comb begin
        res_valid = writes_rd(instr[6:0], instr[14:12], instr[11:7]);
        res_rd    = instr[11:7];
        if (instr[6:0] == OpLoad) res_data = load_ext(instr[14:12], addr[1:0], word);
        else                      res_data = op_imm(instr[14:12], instr[31:20], rs1_val);
    end

    // instr is ignored while reset is held
    always_ff @(posedge clk) begin
        if (reset_n && res_valid) regfile[res_rd] <= res_data;
    end
endmodule

module sodor5_verif #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DMEM_WORDS = 16,
    parameter int unsigned PIPE_LAT   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] instr,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic            mismatch,
    output logic            mismatch_sticky
);
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    logic [PIPE_LAT-1:0] dly_valid_q, dly_valid_d;
    logic [4:0]          dly_rd_q   [PIPE_LAT];
    logic [4:0]          dly_rd_d   [PIPE_LAT];
    logic [31:0]         dly_data_q [PIPE_LAT];
    logic [31:0]         dly_data_d [PIPE_LAT];
    logic                sticky_q, sticky_d;

    sodor5_model #(.NUM_REGS(NUM_REGS), .DMEM_WORDS(DMEM_WORDS)) s5m (
        .clk       (clk),
        .reset_n   (reset_n),
        .instr     (instr),
        .res_valid (m_valid),
        .res_rd    (m_rd),
        .res_data  (m_data)
    );

    sodor5_coretop #(.NUM_REGS(NUM_REGS), .DMEM_WORDS(DMEM_WORDS)) coretop (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr        (instr),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data)
    );

    // Delay line aligns the model result with the pipeline's WB stage
    always_comb begin
        dly_valid_d    = {dly_valid_q[PIPE_LAT-2:0], m_valid};
        dly_rd_d[0]    = m_rd;
        dly_data_d[0]  = m_data;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dly_rd_d[i]   = dly_rd_q[i-1];
            dly_data_d[i] = dly_data_q[i-1];
        end
    end

    always_comb begin
        mismatch = (retire_valid != dly_valid_q[PIPE_LAT-1]);
        if (retire_valid && dly_valid_q[PIPE_LAT-1]) begin
            mismatch = (retire_rd != dly_rd_q[PIPE_LAT-1])
                       || (retire_data != dly_data_q[PIPE_LAT-1]);
        end
        sticky_d        = sticky_q | mismatch;
        mismatch_sticky = sticky_q | mismatch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_valid_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dly_rd_q[i]   <= '0;
                dly_data_q[i] <= '0;
            end
            sticky_q <= 1'b0;
        end else begin
            dly_valid_q <= dly_valid_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dly_rd_q[i]   <= dly_rd_d[i];
                dly_data_q[i] <= dly_data_d[i];
            end
            sticky_q <= sticky_d;
        end
    end
endmodule

// File: tb/tb_sodor5_verif.sv
// Directed bench for sodor5_verif: preloads both engines, streams hand-encoded RV32I
// instructions and checks each writeback four cycles after issue.
module tb_sodor5_verif;
    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        mismatch;
    logic        mismatch_sticky;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ins;
        logic        ev;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    sodor5_verif dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .instr           (instr),
        .retire_valid    (retire_valid),
        .retire_rd       (retire_rd),
        .retire_data     (retire_data),
        .mismatch        (mismatch),
        .mismatch_sticky (mismatch_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_retire(input string tag, input logic ev, input logic [4:0] rd,
                                input logic [31:0] data, input logic mm, input logic st);
        check_eq({tag, " valid"}, {31'd0, retire_valid}, {31'd0, ev});
        if (ev) begin
            check_eq({tag, " rd"}, {27'd0, retire_rd}, {27'd0, rd});
            check_eq({tag, " data"}, retire_data, data);
        end
        check_eq({tag, " mismatch"}, {31'd0, mismatch}, {31'd0, mm});
        check_eq({tag, " sticky"}, {31'd0, mismatch_sticky}, {31'd0, st});
    endtask

    task automatic add(input logic [31:0] ins, input logic ev, input logic [4:0] rd,
                       input logic [31:0] data);
        vec_t v;
        v.ins  = ins;
        v.ev   = ev;
        v.rd   = rd;
        v.data = data;
        vecs.push_back(v);
    endtask

    task automatic set_reg(input int i, input logic [31:0] v);
        dut.s5m.regfile[i] = v;
        dut.coretop.core.d.regfile.regfile[i] = v;
    endtask

    task automatic set_mem(input int i, input logic [31:0] v);
        dut.s5m.dmem.mem[i] = v;
        dut.coretop.dmem.mem[i] = v;
    endtask

    initial begin
        reset_n = 1'b0;
        instr   = 32'h0010_8093;  // addi x1,x1,1: must be ignored under reset
        #1;
        for (int i = 0; i < 32; i++) set_reg(i, 32'd0);
        for (int i = 0; i < 16; i++) set_mem(i, 32'd0);
        set_reg(1, 32'h0000_0005);
        set_reg(3, 32'h0000_0008);
        set_reg(8, 32'h8000_0000);
        set_mem(2, 32'h2222_2222);
        set_mem(15, 32'hFFFF_FFFF);

        add(32'hFFF0_8113, 1'b1, 5'd2,  32'h0000_0004);  // addi x2,x1,-1
        add(32'h0031_C203, 1'b1, 5'd4,  32'h0000_0022);  // lbu  x4,3(x3)
        add(32'h03C0_0583, 1'b1, 5'd11, 32'hFFFF_FFFF);  // lb   x11,0x3c(x0)
        add(32'h0001_A283, 1'b1, 5'd5,  32'h2222_2222);  // lw   x5,0(x3)
        add(32'h0012_8313, 1'b1, 5'd6,  32'h2222_2223);  // addi x6,x5,1 (load-use)
        add(32'h4044_5393, 1'b1, 5'd7,  32'hF800_0000);  // srai x7,x8,4
        add(32'h0044_5393, 1'b1, 5'd7,  32'h0800_0000);  // srli x7,x8,4
        add(32'h0010_3493, 1'b1, 5'd9,  32'h0000_0001);  // sltiu x9,x0,1
        add(32'h0FF0_C613, 1'b1, 5'd12, 32'h0000_00FA);  // xori x12,x1,0xff
        add(32'h0004_2693, 1'b1, 5'd13, 32'h0000_0001);  // slti x13,x8,0
        add(32'h0021_9703, 1'b1, 5'd14, 32'h0000_2222);  // lh   x14,2(x3)
        add(32'h03E0_5783, 1'b1, 5'd15, 32'h0000_FFFF);  // lhu  x15,0x3e(x0)
        add(32'h0070_0813, 1'b1, 5'd16, 32'h0000_0007);  // addi x16,x0,7
        add(Nop,           1'b0, 5'd0,  32'h0);
        add(32'h0018_0893, 1'b1, 5'd17, 32'h0000_0008);  // addi x17,x16,1 (WB fwd)
        add(32'h0028_0913, 1'b1, 5'd18, 32'h0000_0009);  // addi x18,x16,2 (write-first)
        add(32'h0010_0993, 1'b1, 5'd19, 32'h0000_0001);  // addi x19,x0,1
        add(32'h0020_0993, 1'b1, 5'd19, 32'h0000_0002);  // addi x19,x0,2
        add(32'h0009_8A13, 1'b1, 5'd20, 32'h0000_0002);  // addi x20,x19,0 (MEM over WB)
        add(32'h0000_0033, 1'b0, 5'd0,  32'h0);          // unsupported opcode
        add(32'h0001_B283, 1'b0, 5'd0,  32'h0);          // load funct3=3
        add(32'h0050_8013, 1'b0, 5'd0,  32'h0);          // addi x0,x1,5

        // Reset state
        @(negedge clk);
        check_retire("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_eq("reset rd", {27'd0, retire_rd}, 32'd0);
        check_eq("reset data", retire_data, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        instr   = Nop;

        for (int i = 0; i < vecs.size() + 4; i++) begin
            vec_t v;
            @(negedge clk);
            if (i >= 4) v = vecs[i-4];
            else        v = '{ins: Nop, ev: 1'b0, rd: 5'd0, data: 32'd0};
            check_retire($sformatf("v%0d", i - 4), v.ev, v.rd, v.data, 1'b0, 1'b0);
            instr = (i < vecs.size()) ? vecs[i].ins : Nop;
        end

        // Corrupt the pipeline's x1 and read it
        @(negedge clk);
        dut.coretop.core.d.regfile.regfile[1] = 32'hDEAD_0000;
        instr = 32'h0000_8A93;  // addi x21,x1,0
        @(negedge clk);
        instr = Nop;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check_retire("corrupt", 1'b1, 5'd21, 32'hDEAD_0000, 1'b1, 1'b1);
        @(negedge clk);
        check_retire("corrupt+1", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_retire("corrupt+3", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Asynchronous reset with an instruction in flight
        @(negedge clk);
        instr = 32'h0030_0B13;  // addi x22,x0,3
        @(negedge clk);
        instr = Nop;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_retire("async rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_eq("async rst rd", {27'd0, retire_rd}, 32'd0);
        check_eq("async rst data", retire_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_retire($sformatf("flush%0d", i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        end

        // Register contents survive reset
        instr = 32'h0008_0C13;  // addi x24,x16,0
        @(negedge clk);
        instr = Nop;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check_retire("preserve", 1'b1, 5'd24, 32'h0000_0007, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
